// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the MEM-stage load/store port.
// Takes one request at a time, inserts WAIT_CYCLES wait states, performs the access on the
// edge that enters RESP and pulses resp_valid for one cycle.
//
// Ports:
//   clk, rst        - rising-edge clock, asynchronous active-low reset
//   req_valid/ready - request handshake; ready only in IDLE
//   req_wena        - 1 = store, 0 = load
//   req_size        - 00 word, 01 halfword, 10 byte, 11 reserved (error)
//   req_sext        - sign-extend byte/halfword loads
//   req_addr        - byte address; word index is addr[ADDR_W+1:2], upper bits wrap
//   req_wdata       - right-justified store data
//   resp_valid      - one-cycle response pulse
//   resp_rdata      - load result (0 for stores and errors), held until next response
//   resp_err        - misaligned or reserved-size request, held until next response
//   busy            - request in flight (~req_ready)
//
// Optional feature (macro DMEM_ACCESS_CNT_EN): rd_cnt / wr_cnt count completed non-error
// loads / stores, reset to 0 and wrap at 2**32.

module dmem_responder #(
    parameter int unsigned ADDR_W      = 11,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wena,
    input  logic [1:0]  req_size,
    input  logic        req_sext,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
`ifdef DMEM_ACCESS_CNT_EN
    ,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt
`endif
);

    localparam int unsigned Depth    = 2 ** ADDR_W;
    localparam logic [3:0]  WaitInit = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    typedef struct packed {
        logic              wena;
        logic [1:0]        size;
        logic              sext;
        logic [ADDR_W+1:0] addr;
        logic [31:0]       wdata;
    } req_t;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    req_t        req_q, req_d, acc;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    logic              accept, access, acc_err, mem_we;
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        off;
    logic [3:0]        be;
    logic [31:0]       wr_data, rd_word, ld_data;
    logic [15:0]       half_v;
    logic [7:0]        byte_v;
    logic              unused_addr;

    logic [31:0] mem [Depth];

    assign accept      = req_valid & (state_q == StIdle);
    assign unused_addr = ^req_addr[31:ADDR_W+2];

    assign req_d = accept ? '{wena: req_wena, size: req_size, sext: req_sext,
                              addr: req_addr[ADDR_W+1:0], wdata: req_wdata}
                          : req_q;

    // With zero wait states the access happens on the accept edge itself, so the request
    // comes straight from the ports in IDLE; otherwise it comes from the latched copy.
    assign acc = (state_q == StIdle) ? '{wena: req_wena, size: req_size, sext: req_sext,
                                         addr: req_addr[ADDR_W+1:0], wdata: req_wdata}
                                     : req_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        access  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    cnt_d = WaitInit;
                    if (WAIT_CYCLES == 0) begin
                        state_d = StResp;
                        access  = 1'b1;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StResp;
                    access  = 1'b1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign word_idx = acc.addr[ADDR_W+1:2];
    assign off      = acc.addr[1:0];
    assign rd_word  = mem[word_idx];
    assign acc_err  = (acc.size == 2'b11)
                    | ((acc.size == 2'b01) & acc.addr[0])
                    | ((acc.size == 2'b00) & (acc.addr[1:0] != 2'b00));

    // Lane steering: replicate store data across lanes, pick the addressed lane for loads.
    always_comb begin
        be      = 4'b1111;
        wr_data = acc.wdata;
        ld_data = rd_word;
        half_v  = off[1] ? rd_word[31:16] : rd_word[15:0];
        byte_v  = rd_word[8*off +: 8];
        case (acc.size)
            2'b01: begin
                be      = off[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{acc.wdata[15:0]}};
                ld_data = {{16{acc.sext & half_v[15]}}, half_v};
            end
            2'b10: begin
                be      = 4'b0001 << off;
                wr_data = {4{acc.wdata[7:0]}};
                ld_data = {{24{acc.sext & byte_v[7]}}, byte_v};
            end
            default: ;
        endcase
    end

    // rst gate keeps an accept seen while reset is held from committing a write.
    assign mem_we = access & acc.wena & ~acc_err & rst;

    always_comb begin
        resp_valid_d = access;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        if (access) begin
            resp_err_d   = acc_err;
            resp_rdata_d = (acc_err | acc.wena) ? 32'h0 : ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            req_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_q        <= req_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Memory contents are deliberately not reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_we && be[b]) begin
                mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign busy       = ~req_ready;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

`ifdef DMEM_ACCESS_CNT_EN
    logic [31:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if ((state_q == StResp) && !resp_err_q) begin
            if (req_q.wena) wr_cnt_d = wr_cnt_q + 32'd1;
            else            rd_cnt_d = rd_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cnt_q <= 32'h0;
            wr_cnt_q <= 32'h0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign rd_cnt = rd_cnt_q;
    assign wr_cnt = wr_cnt_q;
`endif

endmodule
